// File: rtl/srec_emitter_if.sv
// Handshake and bus bundle for srec_emitter: dump request, memory read port and
// the ASCII character stream.
interface srec_emitter_if;
   logic        start;
   logic [31:0] base_address;
   logic [31:0] byte_count;
   logic        busy;
   logic        done;
   logic [31:0] mem_address;
   logic        mem_wren;
   logic [31:0] mem_data_out;
   logic [7:0]  char_out;
   logic        char_valid;
   logic        char_ready;

   modport master (
      input  start, base_address, byte_count, mem_data_out, char_ready,
      output busy, done, mem_address, mem_wren, char_out, char_valid
   );

   modport slave (
      output start, base_address, byte_count, mem_data_out, char_ready,
      input  busy, done, mem_address, mem_wren, char_out, char_valid
   );
endinterface

// File: rtl/srec_emitter.sv
// Dumps a word-aligned memory region as Motorola S-record text (S3 data records
// followed by one S7 terminator), one ASCII character per valid/ready transfer.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for start
// TYPE0   | 'S'
// TYPE1   | '3' for data records, '7' for the terminator
// COUNT   | two hex digits of the record byte count
// ADDR    | eight hex digits of the record address
// FETCH   | mem_address presented, char_valid low
// WAIT    | read data captured into the word register
// DATA    | eight hex digits of the current word
// CSUM    | two hex digits of the ones-complemented checksum
// EOL     | line feed
// FIN     | done pulse, back to IDLE
module srec_emitter #(
   parameter int RECORD_BYTES = 16
) (
   input logic           clock,
   input logic           reset,
   srec_emitter_if.master bus
);

   typedef enum logic [3:0] {
      S_IDLE, S_TYPE0, S_TYPE1, S_COUNT, S_ADDR, S_FETCH,
      S_WAIT, S_DATA, S_CSUM, S_EOL, S_FIN
   } state_t;

   state_t      state;
   logic [31:0] base_addr, cur_addr, rec_addr, word_reg, mem_address;
   logic [32:0] remaining;
   logic [7:0]  count, csum, char_out;
   logic [3:0]  rec_words;
   logic [2:0]  nib;
   logic        pair, is_s7, busy, done, char_valid;

   logic [32:0] rounded_len, rem_src;
   logic [31:0] base_src, cur_src, new_addr;
   logic [7:0]  new_count, csum_out;
   logic [5:0]  rec_n;
   logic        xfer, new_is_s7, begin_rec;

   function automatic logic [7:0] hex_char(input logic [3:0] v);
      return (v < 4'd10) ? (8'h30 + {4'h0, v}) : (8'h37 + {4'h0, v});
   endfunction

   // Nibble 0 is the most significant one.
   function automatic logic [3:0] nib_sel(input logic [31:0] w, input logic [2:0] i);
      return 4'(w >> {i ^ 3'd7, 2'b00});
   endfunction

   function automatic logic [7:0] byte_sum(input logic [31:0] w);
      return w[31:24] + w[23:16] + w[15:8] + w[7:0];
   endfunction

   // In IDLE the record setup works straight from the request inputs.
   assign rounded_len = ({1'b0, bus.byte_count} + 33'd3) & ~33'd3;
   assign rem_src     = (state == S_IDLE) ? rounded_len : remaining;
   assign base_src    = (state == S_IDLE) ? {bus.base_address[31:2], 2'b00} : base_addr;
   assign cur_src     = (state == S_IDLE) ? {bus.base_address[31:2], 2'b00} : cur_addr;
   assign rec_n       = (rem_src >= 33'(RECORD_BYTES)) ? 6'(RECORD_BYTES) : rem_src[5:0];
   assign new_is_s7   = (rem_src == 33'd0);
   assign new_addr    = new_is_s7 ? base_src : cur_src;
   assign new_count   = {2'b00, rec_n} + 8'd5;
   assign csum_out    = ~csum;
   assign xfer        = char_valid && bus.char_ready;
   assign begin_rec   = (state == S_IDLE && bus.start) || (state == S_EOL && xfer && !is_s7);

   assign bus.busy        = busy;
   assign bus.done        = done;
   assign bus.mem_address = mem_address;
   assign bus.mem_wren    = 1'b0;
   assign bus.char_out    = char_out;
   assign bus.char_valid  = char_valid;

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= S_IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         char_valid  <= 1'b0;
         char_out    <= 8'h00;
         mem_address <= 32'h0;
         base_addr   <= 32'h0;
         cur_addr    <= 32'h0;
         rec_addr    <= 32'h0;
         word_reg    <= 32'h0;
         remaining   <= 33'h0;
         count       <= 8'h0;
         csum        <= 8'h0;
         rec_words   <= 4'h0;
         nib         <= 3'h0;
         pair        <= 1'b0;
         is_s7       <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  base_addr <= base_src;
                  cur_addr  <= cur_src;
               end
            end
            S_TYPE0: if (xfer) begin
               char_out <= is_s7 ? 8'h37 : 8'h33;
               state    <= S_TYPE1;
            end
            S_TYPE1: if (xfer) begin
               char_out <= hex_char(count[7:4]);
               pair     <= 1'b0;
               state    <= S_COUNT;
            end
            S_COUNT: if (xfer) begin
               if (!pair) begin
                  char_out <= hex_char(count[3:0]);
                  pair     <= 1'b1;
               end else begin
                  char_out <= hex_char(rec_addr[31:28]);
                  nib      <= 3'd0;
                  state    <= S_ADDR;
               end
            end
            S_ADDR: if (xfer) begin
               if (nib != 3'd7) begin
                  nib      <= nib + 3'd1;
                  char_out <= hex_char(nib_sel(rec_addr, nib + 3'd1));
               end else if (is_s7) begin
                  char_out <= hex_char(csum_out[7:4]);
                  pair     <= 1'b0;
                  state    <= S_CSUM;
               end else begin
                  char_valid  <= 1'b0;
                  mem_address <= cur_addr;
                  state       <= S_FETCH;
               end
            end
            S_FETCH: begin
               cur_addr <= cur_addr + 32'd4;
               state    <= S_WAIT;
            end
            S_WAIT: begin
               word_reg   <= bus.mem_data_out;
               csum       <= csum + byte_sum(bus.mem_data_out);
               rec_words  <= rec_words - 4'd1;
               char_out   <= hex_char(bus.mem_data_out[31:28]);
               char_valid <= 1'b1;
               nib        <= 3'd0;
               state      <= S_DATA;
            end
            S_DATA: if (xfer) begin
               if (nib != 3'd7) begin
                  nib      <= nib + 3'd1;
                  char_out <= hex_char(nib_sel(word_reg, nib + 3'd1));
               end else if (rec_words != 4'd0) begin
                  char_valid  <= 1'b0;
                  mem_address <= cur_addr;
                  state       <= S_FETCH;
               end else begin
                  char_out <= hex_char(csum_out[7:4]);
                  pair     <= 1'b0;
                  state    <= S_CSUM;
               end
            end
            S_CSUM: if (xfer) begin
               if (!pair) begin
                  char_out <= hex_char(csum_out[3:0]);
                  pair     <= 1'b1;
               end else begin
                  char_out <= 8'h0A;
                  state    <= S_EOL;
               end
            end
            S_EOL: if (xfer && is_s7) begin
               char_valid <= 1'b0;
               busy       <= 1'b0;
               done       <= 1'b1;
               state      <= S_FIN;
            end
            S_FIN: begin
               done  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase

         // Shared entry into a new record, from IDLE or after a data record's LF.
         if (begin_rec) begin
            is_s7      <= new_is_s7;
            rec_addr   <= new_addr;
            count      <= new_is_s7 ? 8'd5 : new_count;
            csum       <= (new_is_s7 ? 8'd5 : new_count) + byte_sum(new_addr);
            rec_words  <= rec_n[5:2];
            remaining  <= rem_src - {27'd0, rec_n};
            char_out   <= 8'h53;
            char_valid <= 1'b1;
            busy       <= 1'b1;
            state      <= S_TYPE0;
         end
      end
   end

endmodule

// File: tb/tb_srec_emitter.sv
// Self-checking bench for srec_emitter: compares the emitted character stream
// against an S-record text model built from a synthetic memory image.
module tb_srec_emitter;
   logic clock = 1'b0;
   logic reset = 1'b1;
   int   n_checks = 0;
   int   n_fail = 0;

   srec_emitter_if bus();

   srec_emitter #(.RECORD_BYTES(16)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      if (a == 32'h80020000) return 32'h3C1D8002;
      return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
   endfunction

   // Memory returns data one cycle after the address.
   always @(posedge clock) bus.mem_data_out <= mem_fn(bus.mem_address);

   logic [31:0] addr_log[$];
   logic [31:0] last_addr = 32'h0;
   always @(negedge clock) begin
      if (bus.mem_address !== last_addr) begin
         addr_log.push_back(bus.mem_address);
         last_addr <= bus.mem_address;
      end
   end

   function automatic string hexs(input logic [31:0] v, input int nd);
      string digits;
      string s;
      int d;
      digits = "0123456789ABCDEF";
      s = "";
      for (int i = nd - 1; i >= 0; i--) begin
         d = int'((v >> (4 * i)) & 32'hF);
         s = $sformatf("%s%c", s, digits[d]);
      end
      return s;
   endfunction

   function automatic int bsum(input logic [31:0] a);
      return int'(a[31:24]) + int'(a[23:16]) + int'(a[15:8]) + int'(a[7:0]);
   endfunction

   function automatic string model(input logic [31:0] b, input logic [31:0] c);
      longint unsigned len;
      logic [31:0] base, addr, w;
      string s;
      int n, sum;
      len  = (longint'(c) + 3) / 4 * 4;
      base = {b[31:2], 2'b00};
      addr = base;
      s    = "";
      while (len > 0) begin
         n   = (len > 16) ? 16 : int'(len);
         sum = n + 5 + bsum(addr);
         s   = {s, "S3", hexs(n + 5, 2), hexs(addr, 8)};
         for (int k = 0; k < n / 4; k++) begin
            w    = mem_fn(addr);
            s    = {s, hexs(w, 8)};
            sum += bsum(w);
            addr = addr + 32'd4;
         end
         s = {s, hexs(~sum & 255, 2), "\n"};
         len -= n;
      end
      s = {s, "S705", hexs(base, 8), hexs(~(5 + bsum(base)) & 255, 2), "\n"};
      return s;
   endfunction

   function automatic string vis(input string s);
      string r;
      r = "";
      foreach (s[i]) r = (s[i] == 8'h0A) ? {r, "|"} : $sformatf("%s%c", r, s[i]);
      return r;
   endfunction

   task automatic run_dump(input logic [31:0] b, input logic [31:0] c, input bit rnd,
                           input bit poke, output string got, output int done_cyc,
                           output int done_cnt, output int proto_err, output bit first_ok);
      int burst;
      bit prev_stall;
      logic [7:0] prev_char;
      burst = 0; prev_stall = 0; prev_char = 8'h00;
      got = ""; done_cyc = 0; done_cnt = 0; proto_err = 0;
      @(posedge clock); #1;
      bus.start = 1'b1; bus.base_address = b; bus.byte_count = c; bus.char_ready = 1'b1;
      @(posedge clock); #1;
      bus.start = 1'b0;
      first_ok = (bus.char_valid === 1'b1) && (bus.char_out === 8'h53) && (bus.busy === 1'b1);
      for (int cyc = 1; cyc < 3000; cyc++) begin
         if (bus.done === 1'b1) begin
            done_cnt++;
            if (done_cyc == 0) done_cyc = cyc;
            if (bus.busy !== 1'b0) proto_err++;
         end
         if (done_cyc != 0 && cyc >= done_cyc + 3) break;
         if (prev_stall && (bus.char_valid !== 1'b1 || bus.char_out !== prev_char)) proto_err++;
         if (poke && cyc == 7) begin
            bus.start = 1'b1; bus.base_address = ~b; bus.byte_count = 32'd100;
         end else begin
            bus.start = 1'b0;
         end
         if (rnd) begin
            if (burst > 0) begin
               bus.char_ready = 1'b0; burst--;
            end else if ($urandom_range(0, 5) == 0) begin
               bus.char_ready = 1'b0; burst = 2;
            end else begin
               bus.char_ready = 1'b1;
            end
         end else begin
            bus.char_ready = 1'b1;
         end
         if (bus.char_valid === 1'b1 && bus.char_ready === 1'b1)
            got = $sformatf("%s%c", got, bus.char_out);
         prev_stall = (bus.char_valid === 1'b1) && !bus.char_ready;
         prev_char  = bus.char_out;
         @(posedge clock); #1;
      end
      bus.start = 1'b0;
      bus.char_ready = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
      n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done); end
      n_checks++; if (bus.char_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.char_valid); end
      n_checks++; if (bus.char_out !== 8'h00) begin n_fail++; $display("FAIL reset_char: got %h expected 00", bus.char_out); end
      n_checks++; if (bus.mem_address !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", bus.mem_address); end
      n_checks++; if (bus.mem_wren !== 1'b0) begin n_fail++; $display("FAIL reset_wren: got %b expected 0", bus.mem_wren); end
      reset = 1'b0;
   endtask

   task automatic test_single_word();
      string got, exp;
      int dc, dn, pe;
      bit fo;
      run_dump(32'h80020000, 32'd4, 0, 0, got, dc, dn, pe, fo);
      exp = {"S30980020000", "3C1D8002", "99\n", "S7058002000078\n"};
      n_checks++; if (got != exp) begin n_fail++; $display("FAIL single_literal: got %s expected %s", vis(got), vis(exp)); end
      n_checks++; if (got != model(32'h80020000, 32'd4)) begin n_fail++; $display("FAIL single_model: got %s expected %s", vis(got), vis(model(32'h80020000, 32'd4))); end
      n_checks++; if (dn !== 1) begin n_fail++; $display("FAIL single_done_count: got %0d expected 1", dn); end
      n_checks++; if (fo !== 1'b1) begin n_fail++; $display("FAIL start_latency: got %b expected 1", fo); end
      n_checks++; if (pe !== 0) begin n_fail++; $display("FAIL single_protocol: got %0d errors expected 0", pe); end
   endtask

   task automatic test_empty();
      string got;
      int dc, dn, pe;
      bit fo;
      run_dump(32'h80020000, 32'd0, 0, 0, got, dc, dn, pe, fo);
      n_checks++; if (got != "S7058002000078\n") begin n_fail++; $display("FAIL empty_stream: got %s expected S7058002000078|", vis(got)); end
      n_checks++; if (dc !== 16) begin n_fail++; $display("FAIL empty_duration: got %0d cycles expected 16", dc); end
      n_checks++; if (dn !== 1) begin n_fail++; $display("FAIL empty_done_count: got %0d expected 1", dn); end
   endtask

   task automatic test_multi_record();
      string got;
      int dc, dn, pe;
      bit fo;
      run_dump(32'h80020000, 32'd20, 0, 0, got, dc, dn, pe, fo);
      n_checks++; if (got != model(32'h80020000, 32'd20)) begin n_fail++; $display("FAIL multi_model: got %s expected %s", vis(got), vis(model(32'h80020000, 32'd20))); end
      n_checks++; if (got.len() !== 85) begin n_fail++; $display("FAIL multi_length: got %0d expected 85", got.len()); end
      n_checks++; if (got.substr(0, 11) != "S31580020000") begin n_fail++; $display("FAIL multi_hdr1: got %s expected S31580020000", got.substr(0, 11)); end
      n_checks++; if (got.substr(47, 58) != "S30980020010") begin n_fail++; $display("FAIL multi_hdr2: got %s expected S30980020010", got.substr(47, 58)); end
   endtask

   task automatic test_round_up();
      string got;
      int dc, dn, pe;
      bit fo;
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      repeat (2) @(posedge clock);
      #1 addr_log.delete();
      run_dump(32'h80020000, 32'd5, 0, 0, got, dc, dn, pe, fo);
      n_checks++; if (got != model(32'h80020000, 32'd5)) begin n_fail++; $display("FAIL round_model: got %s expected %s", vis(got), vis(model(32'h80020000, 32'd5))); end
      n_checks++; if (got.substr(2, 3) != "0D") begin n_fail++; $display("FAIL round_count: got %s expected 0D", got.substr(2, 3)); end
      n_checks++; if (addr_log.size() !== 2) begin n_fail++; $display("FAIL round_reads: got %0d reads expected 2", addr_log.size()); end
      else begin
         n_checks++; if (addr_log[0] !== 32'h80020000) begin n_fail++; $display("FAIL round_addr0: got %h expected 80020000", addr_log[0]); end
         n_checks++; if (addr_log[1] !== 32'h80020004) begin n_fail++; $display("FAIL round_addr1: got %h expected 80020004", addr_log[1]); end
      end
   endtask

   task automatic test_backpressure();
      string ref_got, got;
      int dc, dn, pe;
      bit fo;
      logic [31:0] b;
      b = $urandom;
      run_dump(b, 32'd48, 0, 0, ref_got, dc, dn, pe, fo);
      run_dump(b, 32'd48, 1, 1, got, dc, dn, pe, fo);
      n_checks++; if (got != ref_got) begin n_fail++; $display("FAIL bp_vs_ready: got %s expected %s", vis(got), vis(ref_got)); end
      n_checks++; if (got != model(b, 32'd48)) begin n_fail++; $display("FAIL bp_model: got %s expected %s", vis(got), vis(model(b, 32'd48))); end
      n_checks++; if (pe !== 0) begin n_fail++; $display("FAIL bp_stall_stable: got %0d errors expected 0", pe); end
      n_checks++; if (dn !== 1) begin n_fail++; $display("FAIL bp_done_count: got %0d expected 1", dn); end
   endtask

   task automatic test_reset_mid();
      string got;
      int dc, dn, pe, xc, late_done;
      bit fo, hit;
      xc = 0; hit = 0; late_done = 0;
      @(posedge clock); #1;
      bus.start = 1'b1; bus.base_address = 32'h80020000; bus.byte_count = 32'd20; bus.char_ready = 1'b1;
      @(posedge clock); #1;
      bus.start = 1'b0;
      for (int cyc = 0; cyc < 200 && !hit; cyc++) begin
         if (bus.char_valid === 1'b1 && xc == 53) begin
            reset = 1'b1; hit = 1;
         end else if (bus.char_valid === 1'b1) begin
            xc++;
         end
         @(posedge clock); #1;
      end
      n_checks++; if (hit !== 1'b1) begin n_fail++; $display("FAIL rmid_reach: got %0d chars expected 53", xc); end
      n_checks++; if (bus.char_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b expected 0", bus.char_valid); end
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b expected 0", bus.busy); end
      reset = 1'b0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         if (bus.done === 1'b1) late_done++;
         @(posedge clock); #1;
      end
      n_checks++; if (late_done !== 0) begin n_fail++; $display("FAIL rmid_no_done: got %0d pulses expected 0", late_done); end
      run_dump(32'h80020000, 32'd20, 0, 0, got, dc, dn, pe, fo);
      n_checks++; if (got != model(32'h80020000, 32'd20)) begin n_fail++; $display("FAIL rmid_rerun: got %s expected %s", vis(got), vis(model(32'h80020000, 32'd20))); end
   endtask

   task automatic test_random();
      string got;
      int dc, dn, pe;
      bit fo;
      logic [31:0] b, c;
      for (int i = 0; i < 5; i++) begin
         b = (i == 0) ? 32'hFFFFFFF6 : $urandom;
         c = (i == 0) ? 32'd16 : 32'($urandom_range(0, 40));
         run_dump(b, c, i[0], 0, got, dc, dn, pe, fo);
         n_checks++; if (got != model(b, c)) begin n_fail++; $display("FAIL random_%0d b=%h c=%0d: got %s expected %s", i, b, c, vis(got), vis(model(b, c))); end
         n_checks++; if (dn !== 1) begin n_fail++; $display("FAIL random_done_%0d: got %0d expected 1", i, dn); end
      end
   endtask

   initial begin
      bus.start = 1'b0;
      bus.base_address = 32'h0;
      bus.byte_count = 32'h0;
      bus.char_ready = 1'b1;
      test_reset();
      test_single_word();
      test_empty();
      test_multi_record();
      test_round_up();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
